// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_pkg
//  Brief    : Shared geometry of the 16x8 register file, also used by the
//             UART command decoder.
//  Revision : 1.0
// ============================================================================
package reg_file_pkg;

    localparam int DEPTH  = 16;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_16x8.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_16x8
//  Brief    : 16 x 8-bit flip-flop register file, synchronous write and
//             synchronous clear, combinational read.
//  Revision : 1.0
// ============================================================================
module reg_file_16x8 (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [reg_file_pkg::ADDR_W-1:0] addr,
    input  logic [reg_file_pkg::WIDTH-1:0]  wr_data,
    output logic [reg_file_pkg::WIDTH-1:0]  rd_data
);

    localparam int DEPTH  = reg_file_pkg::DEPTH;
    localparam int WIDTH  = reg_file_pkg::WIDTH;
    localparam int ADDR_W = reg_file_pkg::ADDR_W;

    // Flip-flop array: every entry must clear on reset and read without latency.
    logic [WIDTH-1:0] r_regs [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en) begin
            r_regs[addr] <= wr_data;
        end
    end

    // No bypass: a same-address write shows up only after the edge.
    assign rd_data = r_regs[addr];

endmodule : reg_file_16x8
`default_nettype wire

// File: tb/tb_reg_file_16x8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_16x8
//  Brief    : Self-checking bench for reg_file_16x8 with a queue scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_reg_file_16x8;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;

    logic [7:0] model [16];
    logic [7:0] exp_q [$];
    int         n_vec;
    int         n_err;

    reg_file_16x8 dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", tag, rd_data);
        end else begin
            e = exp_q.pop_front();
            check_vec(tag, rd_data, e);
        end
    endtask

    // One clock cycle of stimulus; rd_data is checked before the edge (old value).
    task automatic drive_cycle(input string tag, input logic r, input logic w,
                               input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        rst = r; wr_en = w; addr = a; wr_data = d;
        exp_q.push_back(model[a]);
        #1 pop_check(tag);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 16; i++) model[i] = 8'h00;
        end else if (w) begin
            model[a] = d;
        end
    endtask

    task automatic read_at(input string tag, input logic [3:0] a);
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0; addr = a; wr_data = 8'h00;
        exp_q.push_back(model[a]);
        #1 pop_check(tag);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; wr_en = 1'b0; addr = 4'd0; wr_data = 8'h00;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        // Reset for 3 cycles; registers are unknown before the first edge.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        read_at("reset_addr3", 4'd3);
        for (int i = 0; i < 16; i++) read_at("reset_all", 4'(i));

        // Write/read, with old value visible during the write cycle.
        drive_cycle("wr3_pre", 1'b0, 1'b1, 4'd3, 8'hB3);
        read_at("rd3", 4'd3);
        check_vec("rd3_const", rd_data, 8'hB3);

        // Independence.
        drive_cycle("wr7_pre", 1'b0, 1'b1, 4'd7, 8'h5A);
        read_at("rd7", 4'd7);
        check_vec("rd7_const", rd_data, 8'h5A);
        read_at("rd3_after7", 4'd3);

        // Write gating.
        drive_cycle("gate_pre", 1'b0, 1'b0, 4'd3, 8'hFF);
        read_at("gate_rd3", 4'd3);
        check_vec("gate_const", rd_data, 8'hB3);

        // Full sweep, back-to-back writes.
        for (int i = 0; i < 16; i++) drive_cycle("sweep_wr", 1'b0, 1'b1, 4'(i), 8'hA0 + 8'(i));
        for (int i = 0; i < 16; i++) read_at("sweep_rd", 4'(i));
        read_at("sweep_15", 4'd15);
        check_vec("sweep_15_const", rd_data, 8'hAF);
        read_at("sweep_0", 4'd0);
        check_vec("sweep_0_const", rd_data, 8'hA0);

        // Random writes with gating mixed in.
        for (int k = 0; k < 40; k++) begin
            drive_cycle("rand", 1'b0, 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 16; i++) read_at("rand_rd", 4'(i));

        // Reset priority over a concurrent write, asserted mid-operation.
        drive_cycle("rstpri_pre", 1'b1, 1'b1, 4'd5, 8'h77);
        read_at("rstpri_rd5", 4'd5);
        check_vec("rstpri_const", rd_data, 8'h00);
        for (int i = 0; i < 16; i++) read_at("rstpri_all", 4'(i));

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_reg_file_16x8
`default_nettype wire

// File: doc/reg_file_16x8.md
REG_FILE_16X8 -- requirements
Module: reg_file_16x8

Interface
- REQ-001 The block SHALL have no overridable parameters.
- REQ-002 The block SHALL define localparam DEPTH, value 16: number of registers.
- REQ-003 The block SHALL define localparam WIDTH, value 8: bits per register.
- REQ-004 The block SHALL define localparam ADDR_W, value 4: address width.
- REQ-005 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst.
- REQ-006 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
- REQ-007 rst  input  1  SHALL be the synchronous, active-high reset.
- REQ-008 wr_en  input  1  SHALL be the write enable, sampled at the rising clk edge.
- REQ-009 addr  input  4  SHALL select the register for both the write and the read path.
- REQ-010 wr_data  input  8  SHALL be the write data, sampled at the rising clk edge.
- REQ-011 rd_data  output  8  SHALL be the read data, driven combinationally.

Function
- REQ-012 Storage SHALL be 16 independent 8-bit registers, indexed 0..15 by addr.
- REQ-013 Write: at a rising clk edge with rst=0 and wr_en=1, reg[addr] SHALL take wr_data.
- REQ-014 A write SHALL change only the addressed register; the other 15 SHALL hold their values.
- REQ-015 With wr_en=0, no register SHALL change, whatever the values on addr and wr_data.
- REQ-016 Read: rd_data SHALL equal reg[addr] combinationally, with zero clock latency.
- REQ-017 A change on addr SHALL be visible on rd_data within the same cycle.
- REQ-018 Write/read on the same address: during the write cycle, rd_data SHALL show the old value.
- REQ-019 After that write edge, rd_data SHALL show the new value; there SHALL be no write-through bypass.
- REQ-020 Every 4-bit addr value SHALL be valid; there SHALL be no out-of-range case and no wrap logic.
- REQ-021 There SHALL be no handshake; a write SHALL complete in the same cycle it is enabled.
- REQ-022 Back-to-back writes on consecutive cycles SHALL be supported.

Reset
- REQ-023 At a rising clk edge with rst=1, all 16 registers SHALL be cleared to 8'h00.
- REQ-024 rst SHALL take priority over wr_en; a write requested in a reset cycle SHALL be discarded.
- REQ-025 During and after reset, rd_data SHALL read 8'h00 for every addr until that register is written.
- REQ-026 Reset asserted mid-operation SHALL clear all registers at the next rising edge.
- REQ-027 There SHALL be no asynchronous reset path.

Structure
- REQ-028 DEPTH, WIDTH and ADDR_W SHALL be placed in a shared package, reg_file_pkg, for reuse by the UART command decoder.
- REQ-029 The block SHALL be a single flat module with no sub-modules.
- REQ-030 The storage SHALL be implemented as a register array (flip-flops, not inferred block RAM), because reads are asynchronous and reset clears every entry.

Verification
- REQ-031 Reset: hold rst=1 for 3 cycles, release, set addr=3 -> rd_data=8'h00.
- REQ-032 Write/read: write addr=3, data=8'hB3 with wr_en=1 for 1 cycle, then wr_en=0, addr=3 -> rd_data=8'hB3.
- REQ-033 Independence: write addr=7, data=8'h5A -> addr=7 reads 8'h5A and addr=3 still reads 8'hB3.
- REQ-034 Write gating: wr_en=0, addr=3, wr_data=8'hFF for 1 cycle -> addr=3 still reads 8'hB3.
- REQ-035 Full sweep: write reg[i]=8'hA0+i for i=0..15, then read all 16 -> every value matches; in particular, addr=15 reads 8'hAF and addr=0 reads 8'hA0.
- REQ-036 Reset priority: set rst=1 and wr_en=1 with addr=5, data=8'h77 -> after the edge, all registers read 8'h00 and addr=5 reads 8'h00.
